// File: rtl/sr_ff_pkg.sv
// sr_ff_pkg: conflict-mode type and shared SR next-state function
package sr_ff_pkg;
  typedef enum logic [1:0] {SR_HOLD, SR_SET_DOM, SR_RESET_DOM, SR_TOGGLE} sr_conflict_e;
  function automatic logic sr_next(input logic q, input logic s, input logic r, input sr_conflict_e mode);
    return (s & r) ? (mode == SR_HOLD ? q : mode == SR_SET_DOM ? 1'b1 : mode == SR_TOGGLE ? ~q : 1'b0)
         : s ? 1'b1 : r ? 1'b0 : q;
  endfunction
endpackage

// File: rtl/sr_ff_bit.sv
// sr_ff_bit: one SR storage cell with registered conflict flag
module sr_ff_bit
  import sr_ff_pkg::*;
#(
  parameter sr_conflict_e MODE = SR_RESET_DOM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic rst_val,
  output logic q,
  output logic q_bar,
  output logic conflict
);
  always_ff @(posedge clk)
    if (!rst_n) begin
      q        <= rst_val;
      conflict <= 1'b0;
    end else begin
      q        <= sr_next(q, s, r, MODE);
      conflict <= s & r;
    end
  // q_bar is an inverter, never a second flop, so it cannot disagree with q
  assign q_bar = ~q;
endmodule

// File: rtl/sr_ff.sv
// sr_ff: bank of independent clocked SR flip-flops
module sr_ff
  import sr_ff_pkg::*;
#(
  parameter int           WIDTH         = 1,
  parameter sr_conflict_e CONFLICT_MODE = SR_RESET_DOM,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] conflict
);
  width_ok: assert property (@(posedge clk) WIDTH >= 1) else $error("sr_ff: WIDTH must be >= 1");
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_ff_bit #(.MODE(CONFLICT_MODE)) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (S[i]),
      .r        (R[i]),
      .rst_val  (RESET_VAL[i]),
      .q        (Q[i]),
      .q_bar    (Q_bar[i]),
      .conflict (conflict[i])
    );
  end
endmodule

// File: tb/tb_sr_ff.sv
// tb_sr_ff: directed self-checking bench for sr_ff across all conflict modes
module tb_sr_ff;
  import sr_ff_pkg::*;
  logic clk = 1'b0;
  logic rst_n, rst4_n;
  logic s1, r1;
  logic [3:0] s4, r4;
  logic qh, qbh, ch, qs, qbs, cs, qr, qbr, cr, qt, qbt, ct;
  logic [3:0] q4, qb4, c4;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sr_ff #(.WIDTH(1), .CONFLICT_MODE(SR_HOLD)) u_h (
    .clk(clk), .rst_n(rst_n), .S(s1), .R(r1), .Q(qh), .Q_bar(qbh), .conflict(ch));
  sr_ff #(.WIDTH(1), .CONFLICT_MODE(SR_SET_DOM)) u_s (
    .clk(clk), .rst_n(rst_n), .S(s1), .R(r1), .Q(qs), .Q_bar(qbs), .conflict(cs));
  sr_ff #(.WIDTH(1)) u_r (
    .clk(clk), .rst_n(rst_n), .S(s1), .R(r1), .Q(qr), .Q_bar(qbr), .conflict(cr));
  sr_ff #(.WIDTH(1), .CONFLICT_MODE(SR_TOGGLE)) u_t (
    .clk(clk), .rst_n(rst_n), .S(s1), .R(r1), .Q(qt), .Q_bar(qbt), .conflict(ct));
  sr_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) u_w (
    .clk(clk), .rst_n(rst4_n), .S(s4), .R(r4), .Q(q4), .Q_bar(qb4), .conflict(c4));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; s1 = 1'b0; r1 = 1'b0; s4 = 4'h0; r4 = 4'h0;
    edge1(); edge1();
    chk("rst_q",  {qh, qs, qr, qt}, 4'b0000);
    chk("rst_qb", {qbh, qbs, qbr, qbt}, 4'b1111);
    chk("rst_c",  {ch, cs, cr, ct}, 4'b0000);
    chk("rst_w4", q4, 4'b1010);
    rst_n = 1'b1; s1 = 1'b1; r1 = 1'b0;
    edge1();
    chk("set_q",  {qh, qs, qr, qt}, 4'b1111);
    chk("set_qb", {qbh, qbs, qbr, qbt}, 4'b0000);
    s1 = 1'b0;
    edge1();
    chk("hold1", {qh, qs, qr, qt}, 4'b1111);
    r1 = 1'b1;
    edge1();
    chk("clr_q",  {qh, qs, qr, qt}, 4'b0000);
    chk("clr_qb", {qbh, qbs, qbr, qbt}, 4'b1111);
    r1 = 1'b0;
    edge1();
    chk("hold0", {qh, qs, qr, qt}, 4'b0000);
    s1 = 1'b1; r1 = 1'b1;
    edge1();
    chk("cfl_q_from0", {qh, qs, qr, qt}, 4'b0101);
    chk("cfl_c",       {ch, cs, cr, ct}, 4'b1111);
    r1 = 1'b0;
    edge1();
    chk("after_cfl_q", {qh, qs, qr, qt}, 4'b1111);
    chk("after_cfl_c", {ch, cs, cr, ct}, 4'b0000);
    r1 = 1'b1;
    edge1();
    chk("mode_sweep", {qh, qs, qr, qt}, 4'b1100);
    chk("cfl_c2",     {ch, cs, cr, ct}, 4'b1111);
    edge1();
    chk("toggle2", {qh, qs, qr, qt}, 4'b1101);
    chk("cfl_c3",  {ch, cs, cr, ct}, 4'b1111);
    edge1();
    chk("toggle3", {qh, qs, qr, qt}, 4'b1100);
    s1 = 1'b0; r1 = 1'b0;
    edge1();
    chk("cfl_drop", {ch, cs, cr, ct}, 4'b0000);
    chk("qb_inv",   {qbh, qbs, qbr, qbt}, 4'b0011);
    // pulses fully between edges must not be sampled
    #2 s1 = 1'b1;
    #2 s1 = 1'b0; r1 = 1'b1;
    #2 r1 = 1'b0;
    edge1();
    chk("pulse_ign", {qh, qs, qr, qt}, 4'b1100);
    chk("pulse_c",   {ch, cs, cr, ct}, 4'b0000);
    rst4_n = 1'b1; s4 = 4'b0101; r4 = 4'b1010;
    edge1();
    chk("w4_load", q4, 4'b0101);
    rst4_n = 1'b0; s4 = 4'hF; r4 = 4'h0;
    edge1();
    chk("w4_rst_q",  q4, 4'b1010);
    chk("w4_rst_qb", qb4, 4'b0101);
    chk("w4_rst_c",  c4, 4'b0000);
    rst4_n = 1'b1; s4 = 4'h0; r4 = 4'hF;
    edge1();
    chk("w4_clr", q4, 4'b0000);
    s4 = 4'b0011; r4 = 4'b0110;
    edge1();
    chk("w4_indep_q",  q4, 4'b0001);
    chk("w4_indep_qb", qb4, 4'b1110);
    chk("w4_indep_c",  c4, 4'b0010);
    s4 = 4'h0; r4 = 4'h0;
    edge1();
    chk("w4_hold", q4, 4'b0001);
    chk("w4_c_drop", c4, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
